// File: rtl/wb_commit_queue_pkg.sv
// Shared types and helpers for the write-back commit queue.
package wb_commit_queue_pkg;

    localparam int unsigned DEFAULT_LANES = 2;
    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned MAX_LANES     = 4;
    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned XLEN          = 64;
    localparam int unsigned CNT_W         = 3;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       result;
        logic [REG_ADDR_W-1:0] dst;
        logic                  regwrite;
        logic                  is_bubble;
    } wb_entry_t;

    localparam int unsigned ENTRY_W = $bits(wb_entry_t);

    // Number of set bits in a lane mask of up to MAX_LANES lanes.
    function automatic logic [CNT_W-1:0] popCount(input logic [MAX_LANES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(MAX_LANES); i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/wb_group_fifo.sv
// Circular buffer of write-back groups with push/pop/flush and occupancy count.
module wb_group_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             wrEn;
    logic             rdEn;

    // Flush and reset win over any same-cycle transfer.
    assign wrEn  = push && !flush && !reset;
    assign rdEn  = pop && !flush && !reset;
    assign rdata = mem[rdPtr];

    // Payload storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (rdEn) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            occupancy <= occupancy + OCC_W'(wrEn) - OCC_W'(rdEn);
        end
    end

endmodule

// File: rtl/wb_commit_queue.sv
// Write-back commit queue: buffers groups and decodes the head group into RF writes.
// Optional macro WB_DIFFTEST_EN adds commit_valid/commit_pc trace outputs.
module wb_commit_queue
    import wb_commit_queue_pkg::*;
#(
    parameter int unsigned LANES = DEFAULT_LANES,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  wb_entry_t [LANES-1:0]            in_group,
    input  logic                             flush,
    input  logic                             stall,
    output logic [LANES-1:0]                 rf_wen,
    output logic [LANES-1:0][REG_ADDR_W-1:0] rf_waddr,
    output logic [LANES-1:0][XLEN-1:0]       rf_wdata,
    output logic                             handin,
    output logic [CNT_W-1:0]                 commit_cnt,
    output logic [$clog2(DEPTH):0]           occupancy
`ifdef WB_DIFFTEST_EN
    ,
    output logic [LANES-1:0]                 commit_valid,
    output logic [LANES-1:0][XLEN-1:0]       commit_pc
`endif
);

    localparam int unsigned OCC_W   = $clog2(DEPTH) + 1;
    localparam int unsigned GROUP_W = LANES * ENTRY_W;

    wb_entry_t [LANES-1:0] headGroup;
    logic                  doPush;
    logic                  doPop;
    logic [LANES-1:0]      laneCommit;
    logic [LANES-1:0]      wenRaw;

    assign in_ready = occupancy < OCC_W'(DEPTH);
    assign doPush   = in_valid && in_ready && !flush && !reset;
    assign doPop    = (occupancy != '0) && !stall && !flush && !reset;

    wb_group_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (GROUP_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (doPush),
        .pop       (doPop),
        .flush     (flush),
        .wdata     (in_group),
        .rdata     (headGroup),
        .occupancy (occupancy)
    );

    // Decode head group; on a dst collision only the highest committing lane writes.
    always_comb begin
        laneCommit = '0;
        wenRaw     = '0;
        rf_wen     = '0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            laneCommit[i] = doPop && !headGroup[i].is_bubble;
            wenRaw[i]     = laneCommit[i] && headGroup[i].regwrite
                            && (headGroup[i].dst != REG_ADDR_W'(0));
            if (laneCommit[i]) begin
                rf_waddr[i] = headGroup[i].dst;
                rf_wdata[i] = headGroup[i].result;
            end
        end
        for (int i = 0; i < int'(LANES); i++) begin
            rf_wen[i] = wenRaw[i];
            for (int j = i + 1; j < int'(LANES); j++) begin
                if (wenRaw[j] && (headGroup[j].dst == headGroup[i].dst)) begin
                    rf_wen[i] = 1'b0;
                end
            end
        end
    end

    assign commit_cnt = popCount(MAX_LANES'(laneCommit));
    assign handin     = (commit_cnt != '0);

`ifdef WB_DIFFTEST_EN
    always_comb begin
        commit_valid = laneCommit;
        commit_pc    = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (laneCommit[i]) begin
                commit_pc[i] = headGroup[i].pc;
            end
        end
    end
`else
    // The pc field only feeds the trace port; fold it away when that port is absent.
    logic unusedPc;
    always_comb begin
        unusedPc = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            unusedPc = unusedPc ^ (^headGroup[i].pc);
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed self-checking bench for wb_commit_queue (LANES=2, DEPTH=4).
module tb_wb_commit_queue;
    import wb_commit_queue_pkg::*;

    localparam int unsigned LANES = 2;
    localparam int unsigned DEPTH = 4;

    logic                  clk;
    logic                  reset;
    logic                  inValid;
    logic                  inReady;
    wb_entry_t [LANES-1:0] inGroup;
    logic                  flush;
    logic                  stall;
    logic [LANES-1:0]      rfWen;
    logic [LANES-1:0][4:0] rfWaddr;
    logic [LANES-1:0][63:0] rfWdata;
    logic                  handin;
    logic [2:0]            commitCnt;
    logic [2:0]            occupancy;
`ifdef WB_DIFFTEST_EN
    logic [LANES-1:0]       commitValid;
    logic [LANES-1:0][63:0] commitPc;
`endif

    int checks   = 0;
    int failures = 0;

    wb_commit_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_group   (inGroup),
        .flush      (flush),
        .stall      (stall),
        .rf_wen     (rfWen),
        .rf_waddr   (rfWaddr),
        .rf_wdata   (rfWdata),
        .handin     (handin),
        .commit_cnt (commitCnt),
        .occupancy  (occupancy)
`ifdef WB_DIFFTEST_EN
        ,
        .commit_valid (commitValid),
        .commit_pc    (commitPc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic wb_entry_t mkEntry(input logic [63:0] pc, input logic [63:0] res,
                                          input logic [4:0] dst, input logic rw, input logic bub);
        wb_entry_t e;
        e.pc        = pc;
        e.result    = res;
        e.dst       = dst;
        e.regwrite  = rw;
        e.is_bubble = bub;
        return e;
    endfunction

    function automatic wb_entry_t bubble();
        return mkEntry(64'h0, 64'h0, 5'd0, 1'b0, 1'b1);
    endfunction

    // Inputs change on the falling edge; outputs are checked 1ns later.
    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        inValid = 1'b1;
        flush   = 1'b0;
        stall   = 1'b0;
        inGroup[0] = mkEntry(64'hDEAD, 64'h55, 5'd9, 1'b1, 1'b0);
        inGroup[1] = bubble();
        @(negedge clk);
        nextCycle();
        #1;
        checkEq("rst_wen", 64'(rfWen), 64'd0);
        checkEq("rst_handin", 64'(handin), 64'd0);
        checkEq("rst_cnt", 64'(commitCnt), 64'd0);

        // Release reset: the group offered during reset must not have been taken.
        reset   = 1'b0;
        inValid = 1'b0;
        #1;
        checkEq("post_rst_occ", 64'(occupancy), 64'd0);
        checkEq("post_rst_ready", 64'(inReady), 64'd1);

        // Single group, lane1 bubble.
        inValid = 1'b1;
        inGroup[0] = mkEntry(64'h1000, 64'h11, 5'd3, 1'b1, 1'b0);
        inGroup[1] = bubble();
        #1;
        checkEq("lat_handin", 64'(handin), 64'd0);
        nextCycle();
        inValid = 1'b0;
        #1;
        checkEq("one_wen", 64'(rfWen), 64'b01);
        checkEq("one_waddr", 64'(rfWaddr[0]), 64'd3);
        checkEq("one_wdata", rfWdata[0], 64'h11);
        checkEq("one_handin", 64'(handin), 64'd1);
        checkEq("one_cnt", 64'(commitCnt), 64'd1);
        nextCycle();
        #1;
        checkEq("one_drain_occ", 64'(occupancy), 64'd0);
        checkEq("one_drain_handin", 64'(handin), 64'd0);

        // Fill under stall, refuse a fifth, then drain in order.
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            inValid = 1'b1;
            inGroup[0] = mkEntry(64'h2000 + 64'(k), 64'h20 + 64'(k), 5'(k + 1), 1'b1, 1'b0);
            inGroup[1] = bubble();
            nextCycle();
        end
        inGroup[0] = mkEntry(64'h2004, 64'h24, 5'd20, 1'b1, 1'b0);
        #1;
        checkEq("full_occ", 64'(occupancy), 64'd4);
        checkEq("full_ready", 64'(inReady), 64'd0);
        checkEq("stall_handin", 64'(handin), 64'd0);
        checkEq("stall_waddr", 64'(rfWaddr), 64'd0);
        checkEq("stall_wdata", rfWdata[0], 64'd0);
        nextCycle();
        inValid = 1'b0;
        stall   = 1'b0;
        #1;
        checkEq("refused_occ", 64'(occupancy), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkEq($sformatf("drain%0d_waddr", k), 64'(rfWaddr[0]), 64'(k + 1));
            checkEq($sformatf("drain%0d_wdata", k), rfWdata[0], 64'h20 + 64'(k));
            checkEq($sformatf("drain%0d_handin", k), 64'(handin), 64'd1);
            nextCycle();
            #1;
        end
        checkEq("drained_occ", 64'(occupancy), 64'd0);
        checkEq("drained_handin", 64'(handin), 64'd0);
        checkEq("drained_ready", 64'(inReady), 64'd1);

        // Both lanes write r7: only lane1 keeps its enable.
        inValid = 1'b1;
        inGroup[0] = mkEntry(64'h3000, 64'hA, 5'd7, 1'b1, 1'b0);
        inGroup[1] = mkEntry(64'h3004, 64'hB, 5'd7, 1'b1, 1'b0);
        nextCycle();
        inValid = 1'b0;
        #1;
        checkEq("coll_wen", 64'(rfWen), 64'b10);
        checkEq("coll_wdata1", rfWdata[1], 64'hB);
        checkEq("coll_waddr1", 64'(rfWaddr[1]), 64'd7);
        checkEq("coll_cnt", 64'(commitCnt), 64'd2);
        nextCycle();

        // All-bubble group pops without committing.
        inValid = 1'b1;
        inGroup[0] = bubble();
        inGroup[1] = bubble();
        nextCycle();
        inValid = 1'b0;
        #1;
        checkEq("bub_occ", 64'(occupancy), 64'd1);
        checkEq("bub_handin", 64'(handin), 64'd0);
        checkEq("bub_cnt", 64'(commitCnt), 64'd0);
        checkEq("bub_wen", 64'(rfWen), 64'd0);
        nextCycle();
        #1;
        checkEq("bub_popped_occ", 64'(occupancy), 64'd0);

        // Three buffered, then flush with a same-cycle push.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inValid = 1'b1;
            inGroup[0] = mkEntry(64'h5000 + 64'(k), 64'h50 + 64'(k), 5'd4, 1'b1, 1'b0);
            inGroup[1] = bubble();
            #1;
            checkEq($sformatf("preflush%0d_handin", k), 64'(handin), 64'd0);
            nextCycle();
        end
        #1;
        checkEq("preflush_occ", 64'(occupancy), 64'd3);
        stall = 1'b0;
        flush = 1'b1;
        inValid = 1'b1;
        inGroup[0] = mkEntry(64'h5FFF, 64'h5F, 5'd9, 1'b1, 1'b0);
        #1;
        checkEq("flush_cyc_handin", 64'(handin), 64'd0);
        checkEq("flush_cyc_wen", 64'(rfWen), 64'd0);
        nextCycle();
        flush = 1'b0;
        inValid = 1'b0;
        #1;
        checkEq("flush_occ", 64'(occupancy), 64'd0);
        checkEq("flush_after_handin", 64'(handin), 64'd0);
        nextCycle();
        #1;
        checkEq("flush_after2_handin", 64'(handin), 64'd0);
        checkEq("flush_after2_occ", 64'(occupancy), 64'd0);

        // Streaming ten groups back to back.
        for (int k = 0; k <= 10; k++) begin
            inValid = (k < 10);
            inGroup[0] = mkEntry(64'h6000 + 64'(k), 64'h100 + 64'(k), 5'd5, 1'b1, 1'b0);
            inGroup[1] = bubble();
            #1;
            if (k > 0) begin
                checkEq($sformatf("stream%0d_occ", k), 64'(occupancy), 64'd1);
                checkEq($sformatf("stream%0d_wdata", k), rfWdata[0], 64'h100 + 64'(k - 1));
            end
            nextCycle();
        end
        #1;
        checkEq("stream_end_occ", 64'(occupancy), 64'd0);

        // dst=0 commits but never writes the register file.
        inValid = 1'b1;
        inGroup[0] = mkEntry(64'h4000, 64'h77, 5'd0, 1'b1, 1'b0);
        inGroup[1] = bubble();
        nextCycle();
        inValid = 1'b0;
        #1;
        checkEq("r0_wen", 64'(rfWen), 64'd0);
        checkEq("r0_handin", 64'(handin), 64'd1);
        checkEq("r0_cnt", 64'(commitCnt), 64'd1);
`ifdef WB_DIFFTEST_EN
        checkEq("r0_cvalid", 64'(commitValid), 64'b01);
        checkEq("r0_cpc", commitPc[0], 64'h4000);
`endif
        nextCycle();

        // Reset mid-operation drops buffered groups.
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            inValid = 1'b1;
            inGroup[0] = mkEntry(64'h7000 + 64'(k), 64'h70, 5'd6, 1'b1, 1'b0);
            inGroup[1] = bubble();
            nextCycle();
        end
        inValid = 1'b0;
        stall = 1'b0;
        reset = 1'b1;
        #1;
        checkEq("midrst_handin", 64'(handin), 64'd0);
        checkEq("midrst_wen", 64'(rfWen), 64'd0);
        nextCycle();
        reset = 1'b0;
        #1;
        checkEq("midrst_occ", 64'(occupancy), 64'd0);
        checkEq("midrst_after_handin", 64'(handin), 64'd0);
        checkEq("midrst_ready", 64'(inReady), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
